chip_load_sequencer: RTL and testbench

- Host-side transmitter that fills the accelerator chip's on-chip memories over the a/b write interface, then launches one tile computation.
- Per accepted command it streams words in a fixed order: kernel memory, then input (feature-map) memory, then overlap cache.
- Words are read from a host source memory; each is emitted as an address word on a_input and a data word on b_input.
- When loading is complete it pulses start, holds data_ready, and waits for fsm_done.

---
 rtl/chip_load_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_chip_load_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/chip_load_sequencer.sv
// Host-side loader: streams kernel, input and overlap words from a source memory into the
// chip over the a/b write interface, then launches one tile and waits for completion.
module chip_load_sequencer #(
  parameter int unsigned IO_DATA_WIDTH  = 16,
  parameter int unsigned SRC_ADDR_WIDTH = 20,
  parameter int unsigned KERNEL_WORDS   = 512,
  parameter int unsigned INPUT_WORDS    = 16384,
  parameter int unsigned OVERLAP_WORDS  = 256,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      arst_n_in,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [SRC_ADDR_WIDTH-1:0] cmd_kernel_base,
  input  logic [SRC_ADDR_WIDTH-1:0] cmd_input_base,
  input  logic [SRC_ADDR_WIDTH-1:0] cmd_overlap_base,
  input  logic                      cmd_skip_kernel,
  input  logic                      cmd_zero_input,
  output logic                      src_read_en,
  output logic [SRC_ADDR_WIDTH-1:0] src_read_addr,
  input  logic [IO_DATA_WIDTH-1:0]  src_qout,
  output logic [IO_DATA_WIDTH-1:0]  a_input,
  output logic                      a_valid,
  output logic [IO_DATA_WIDTH-1:0]  b_input,
  output logic                      b_valid,
  output logic                      int_mem_we,
  output logic                      overlap_cache_we,
  output logic                      b_zero,
  output logic                      start,
  output logic                      data_ready,
  input  logic                      fsm_done,
  output logic                      busy,
  output logic [COUNT_WIDTH-1:0]    tiles_done
);

  localparam int unsigned CntW = 14;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StKernel   = 3'd1;
  localparam logic [2:0] StInput    = 3'd2;
  localparam logic [2:0] StOverlap  = 3'd3;
  localparam logic [2:0] StFlush    = 3'd4;
  localparam logic [2:0] StStart    = 3'd5;
  localparam logic [2:0] StWaitDone = 3'd6;

  localparam logic [1:0] PhKernel  = 2'd0;
  localparam logic [1:0] PhInput   = 2'd1;
  localparam logic [1:0] PhOverlap = 2'd2;

  localparam logic [CntW-1:0] KLast = CntW'(KERNEL_WORDS - 1);
  localparam logic [CntW-1:0] ILast = CntW'(INPUT_WORDS - 1);
  localparam logic [CntW-1:0] OLast = CntW'(OVERLAP_WORDS - 1);

  logic [2:0]                state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [SRC_ADDR_WIDTH-1:0] kbase_q, ibase_q, obase_q;
  logic                      zero_q;
  logic                      beat_vld_q, beat_zero_q;
  logic [1:0]                beat_ph_q;
  logic [CntW-1:0]           beat_idx_q;
  logic [COUNT_WIDTH-1:0]    tiles_q;

  logic                      accept, rd_live, tile_done;
  logic [1:0]                rd_ph;
  logic [SRC_ADDR_WIDTH-1:0] rd_base;

  assign accept    = cmd_valid && (state_q == StIdle);
  assign tile_done = (state_q == StWaitDone) && fsm_done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cmd_valid) state_d = cmd_skip_kernel ? StInput : StKernel;
      end
      StKernel: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == KLast) begin
          state_d = StInput;
          cnt_d   = '0;
        end
      end
      StInput: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ILast) begin
          state_d = StOverlap;
          cnt_d   = '0;
        end
      end
      StOverlap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == OLast) begin
          state_d = StFlush;
          cnt_d   = '0;
        end
      end
      StFlush:    state_d = StStart;
      StStart:    state_d = StWaitDone;
      StWaitDone: if (fsm_done) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Stage 0: read address and the phase tag that follows the word into stage 1.
  always_comb begin
    rd_live = 1'b0;
    rd_ph   = PhKernel;
    rd_base = kbase_q;
    case (state_q)
      StKernel:  rd_live = 1'b1;
      StInput: begin
        rd_live = 1'b1;
        rd_ph   = PhInput;
        rd_base = ibase_q;
      end
      StOverlap: begin
        rd_live = 1'b1;
        rd_ph   = PhOverlap;
        rd_base = obase_q;
      end
      default: ;
    endcase
  end

  assign src_read_en   = rd_live && !((state_q == StInput) && zero_q);
  assign src_read_addr = src_read_en ? rd_base + SRC_ADDR_WIDTH'(cnt_q) : '0;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      kbase_q     <= '0;
      ibase_q     <= '0;
      obase_q     <= '0;
      zero_q      <= 1'b0;
      beat_vld_q  <= 1'b0;
      beat_zero_q <= 1'b0;
      beat_ph_q   <= PhKernel;
      beat_idx_q  <= '0;
      tiles_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_vld_q  <= rd_live;
      beat_zero_q <= (state_q == StInput) && zero_q;
      beat_ph_q   <= rd_ph;
      beat_idx_q  <= cnt_q;
      if (accept) begin
        kbase_q <= cmd_kernel_base;
        ibase_q <= cmd_input_base;
        obase_q <= cmd_overlap_base;
        zero_q  <= cmd_zero_input;
      end
      if (tile_done) tiles_q <= tiles_q + 1'b1;
    end
  end

  // Stage 1: one write beat per cycle for the word read in the previous cycle.
  always_comb begin
    a_input          = '0;
    int_mem_we       = 1'b0;
    overlap_cache_we = 1'b0;
    if (beat_vld_q) begin
      case (beat_ph_q)
        PhKernel: begin
          a_input[IO_DATA_WIDTH-1] = 1'b1;
          a_input[8:0]             = beat_idx_q[8:0];
          int_mem_we               = 1'b1;
        end
        PhInput: begin
          a_input[13:0] = beat_idx_q[13:0];
          int_mem_we    = 1'b1;
        end
        default: begin
          a_input[7:0]     = beat_idx_q[7:0];
          overlap_cache_we = 1'b1;
        end
      endcase
    end
  end

  assign a_valid    = beat_vld_q;
  assign b_valid    = beat_vld_q;
  assign b_zero     = beat_vld_q && beat_zero_q;
  assign b_input    = (beat_vld_q && !beat_zero_q) ? src_qout : '0;
  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign start      = (state_q == StStart);
  assign data_ready = (state_q == StStart) || (state_q == StWaitDone);
  assign tiles_done = tiles_q;

endmodule

// File: tb/tb_chip_load_sequencer.sv
// Directed bench for chip_load_sequencer with small memories; a tiny source memory returns
// each word's own address so beat data can be predicted from the read schedule.
module tb_chip_load_sequencer;

  localparam int unsigned IW_D = 16;
  localparam int unsigned AW   = 20;
  localparam int unsigned KW   = 4;
  localparam int unsigned NW   = 8;
  localparam int unsigned OW   = 2;
  localparam int unsigned CW   = 2;

  localparam logic [AW-1:0] KBase = 20'h00100;
  localparam logic [AW-1:0] IBase = 20'h00200;
  localparam logic [AW-1:0] OBase = 20'h00300;

  logic            clk = 1'b0;
  logic            arst_n_in;
  logic            cmd_valid, cmd_ready, cmd_skip_kernel, cmd_zero_input;
  logic [AW-1:0]   cmd_kernel_base, cmd_input_base, cmd_overlap_base;
  logic            src_read_en;
  logic [AW-1:0]   src_read_addr;
  logic [IW_D-1:0] src_qout = '0;
  logic [IW_D-1:0] a_input, b_input;
  logic            a_valid, b_valid, int_mem_we, overlap_cache_we, b_zero;
  logic            start, data_ready, fsm_done, busy;
  logic [CW-1:0]   tiles_done;

  int n_cmp = 0;
  int n_err = 0;

  chip_load_sequencer #(
    .IO_DATA_WIDTH (IW_D),
    .SRC_ADDR_WIDTH(AW),
    .KERNEL_WORDS  (KW),
    .INPUT_WORDS   (NW),
    .OVERLAP_WORDS (OW),
    .COUNT_WIDTH   (CW)
  ) u_dut (
    .clk             (clk),
    .arst_n_in       (arst_n_in),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_kernel_base (cmd_kernel_base),
    .cmd_input_base  (cmd_input_base),
    .cmd_overlap_base(cmd_overlap_base),
    .cmd_skip_kernel (cmd_skip_kernel),
    .cmd_zero_input  (cmd_zero_input),
    .src_read_en     (src_read_en),
    .src_read_addr   (src_read_addr),
    .src_qout        (src_qout),
    .a_input         (a_input),
    .a_valid         (a_valid),
    .b_input         (b_input),
    .b_valid         (b_valid),
    .int_mem_we      (int_mem_we),
    .overlap_cache_we(overlap_cache_we),
    .b_zero          (b_zero),
    .start           (start),
    .data_ready      (data_ready),
    .fsm_done        (fsm_done),
    .busy            (busy),
    .tiles_done      (tiles_done)
  );

  always #5 clk = ~clk;

  // Synchronous source memory: word content equals its address.
  always_ff @(posedge clk) begin
    if (src_read_en) src_qout <= src_read_addr[IW_D-1:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".src_read_en"}, 32'(src_read_en), 32'd0);
    check_eq({tag, ".a_valid"}, 32'(a_valid), 32'd0);
    check_eq({tag, ".b_valid"}, 32'(b_valid), 32'd0);
    check_eq({tag, ".start"}, 32'(start), 32'd0);
    check_eq({tag, ".data_ready"}, 32'(data_ready), 32'd0);
  endtask

  // Issues one command at edge 0 and checks every cycle through completion.
  // fsm_done is pulsed in cycle 6 (load phase), optionally in the START cycle, and at start+5.
  task automatic run_tile(input bit skip, input bit zero, input bit done_in_start,
                          input int exp_tiles);
    int            k, s, ph, idx, pr_ph;
    bit            rd, pr_rd, exp_en;
    logic [AW-1:0] addr, pr_addr;
    logic [15:0]   exp_a;
    k = skip ? 0 : int'(KW);
    s = k + int'(NW) + int'(OW) + 2;
    cmd_kernel_base  = KBase;
    cmd_input_base   = IBase;
    cmd_overlap_base = OBase;
    cmd_skip_kernel  = skip;
    cmd_zero_input   = zero;
    cmd_valid        = 1'b1;
    step();
    cmd_valid        = 1'b0;
    cmd_skip_kernel  = 1'b0;
    cmd_zero_input   = 1'b0;
    pr_rd = 1'b0; pr_ph = 0; pr_addr = '0;
    for (int c = 1; c <= s + 6; c++) begin
      rd = 1'b1; ph = 0; idx = 0; addr = '0;
      if (c <= k) begin
        idx = c - 1; addr = KBase + AW'(idx);
      end else if (c <= k + int'(NW)) begin
        ph = 1; idx = c - k - 1; addr = IBase + AW'(idx);
      end else if (c <= k + int'(NW) + int'(OW)) begin
        ph = 2; idx = c - k - int'(NW) - 1; addr = OBase + AW'(idx);
      end else begin
        rd = 1'b0;
      end
      exp_en = rd && !(zero && ph == 1);
      check_eq("src_read_en", 32'(src_read_en), 32'(exp_en));
      if (exp_en) check_eq("src_read_addr", 32'(src_read_addr), 32'(addr));
      check_eq("a_valid", 32'(a_valid), 32'(pr_rd));
      check_eq("b_valid", 32'(b_valid), 32'(pr_rd));
      if (pr_rd) begin
        if (pr_ph == 0)      exp_a = 16'h8000 | 16'(pr_addr - KBase);
        else if (pr_ph == 1) exp_a = 16'(pr_addr - IBase);
        else                 exp_a = 16'(pr_addr - OBase);
        check_eq("a_input", 32'(a_input), 32'(exp_a));
        check_eq("b_input", 32'(b_input),
                 (zero && pr_ph == 1) ? 32'd0 : 32'(pr_addr[15:0]));
        check_eq("int_mem_we", 32'(int_mem_we), 32'(pr_ph != 2));
        check_eq("overlap_cache_we", 32'(overlap_cache_we), 32'(pr_ph == 2));
        check_eq("b_zero", 32'(b_zero), 32'(zero && pr_ph == 1));
      end
      check_eq("start", 32'(start), 32'(c == s));
      check_eq("data_ready", 32'(data_ready), 32'(c >= s && c <= s + 5));
      check_eq("busy", 32'(busy), 32'(c <= s + 5));
      check_eq("cmd_ready", 32'(cmd_ready), 32'(c > s + 5));
      if (c == s) check_eq("tiles_before", 32'(tiles_done), 32'((exp_tiles + 3) % 4));
      if (c == s + 6) check_eq("tiles_after", 32'(tiles_done), 32'(exp_tiles % 4));
      fsm_done = (c == 6) || (done_in_start && c == s) || (c == s + 5);
      pr_rd = rd; pr_ph = ph; pr_addr = addr;
      step();
    end
    fsm_done = 1'b0;
  endtask

  initial begin
    arst_n_in        = 1'b0;
    cmd_valid        = 1'b0;
    cmd_skip_kernel  = 1'b0;
    cmd_zero_input   = 1'b0;
    cmd_kernel_base  = '0;
    cmd_input_base   = '0;
    cmd_overlap_base = '0;
    fsm_done         = 1'b0;
    #3;
    check_idle_outputs("reset");
    check_eq("reset.tiles_done", 32'(tiles_done), 32'd0);
    #9 arst_n_in = 1'b1;
    step();
    check_idle_outputs("post_reset");

    run_tile(1'b0, 1'b0, 1'b0, 1);

    // Abort mid-load: reset asserted between edges in cycle 7.
    cmd_kernel_base  = KBase;
    cmd_input_base   = IBase;
    cmd_overlap_base = OBase;
    cmd_valid        = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_eq("pre_abort.busy", 32'(busy), 32'd1);
    #2 arst_n_in = 1'b0;
    #1;
    check_idle_outputs("abort");
    check_eq("abort.tiles_done", 32'(tiles_done), 32'd0);
    check_eq("abort.int_mem_we", 32'(int_mem_we), 32'd0);
    #1 arst_n_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("after_abort.a_valid", 32'(a_valid), 32'd0);
      check_eq("after_abort.src_read_en", 32'(src_read_en), 32'd0);
      check_eq("after_abort.start", 32'(start), 32'd0);
    end
    check_eq("after_abort.tiles_done", 32'(tiles_done), 32'd0);

    run_tile(1'b1, 1'b0, 1'b1, 1);
    run_tile(1'b0, 1'b1, 1'b0, 2);
    run_tile(1'b0, 1'b0, 1'b0, 3);
    run_tile(1'b0, 1'b0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
